// File: rtl/layer_train_sequencer_pkg.sv
// Shared types for the layer training sequencer: fixed-point neuron value,
// FSM state encoding and layer geometry.
package layer_train_sequencer_pkg;

    typedef logic [7:0] zero2one_t;

    localparam int Z_W           = $bits(zero2one_t);
    localparam int LAYER_NEURONS = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        SETTLE,
        LEARN,
        HOLD,
        EMIT
    } layer_seq_state_t;

    function automatic zero2one_t z2o_absdiff(input zero2one_t a, input zero2one_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/layer_train_sequencer_abs_err_sum.sv
// Combinational sum of |expected - actual| over all layer neurons.
// Only built when LAYER_TRAIN_SEQ_ERR_ACC_EN is defined.
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
module zero2one_abs_err_sum
    import layer_train_sequencer_pkg::*;
(
    input  logic [LAYER_NEURONS*Z_W-1:0] expected_i,
    input  logic [LAYER_NEURONS*Z_W-1:0] actual_i,
    output logic [Z_W+3:0]               sum_o
);

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < LAYER_NEURONS; k++) begin
            sum_o = sum_o + {4'b0000, z2o_absdiff(expected_i[k*Z_W +: Z_W], actual_i[k*Z_W +: Z_W])};
        end
    end

endmodule
`endif

// File: rtl/layer_train_sequencer.sv
// Sequences labelled samples through a 16-neuron layer (eval, settle, optional learn) and returns captured outputs.
// Latency: accept at t -> eval t+1, result t+2+SETTLE_CYC (+1+LEARN_CYC when training); EMIT holds until res_ready.
// LAYER_TRAIN_SEQ_ERR_ACC_EN adds a per-epoch saturating absolute-error accumulator (epoch_err/epoch_err_valid).
module layer_train_sequencer
    import layer_train_sequencer_pkg::*;
#(
    parameter int N          = 16,
    parameter int SAMPLE_W   = 12,
    parameter int EPOCH_W    = 8,
    parameter int SETTLE_CYC = 2,
    parameter int LEARN_CYC  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         train,
    input  logic [SAMPLE_W-1:0]          num_samples,
    input  logic [EPOCH_W-1:0]           num_epochs,
    input  logic                         smp_valid,
    output logic                         smp_ready,
    input  logic [N*Z_W-1:0]             smp_in,
    input  logic [LAYER_NEURONS*Z_W-1:0] smp_expected,
    output logic                         layer_valid,
    output logic                         layer_learn,
    output logic [N*Z_W-1:0]             layer_in,
    output logic [LAYER_NEURONS*Z_W-1:0] layer_expected,
    input  logic [LAYER_NEURONS*Z_W-1:0] layer_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [LAYER_NEURONS*Z_W-1:0] res_out,
    output logic [SAMPLE_W-1:0]          res_sample_idx,
    output logic                         busy,
    output logic                         done,
    output logic [EPOCH_W-1:0]           epoch_idx
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
    ,
    output logic [Z_W+SAMPLE_W+3:0]      epoch_err,
    output logic                         epoch_err_valid
`endif
);

    localparam int CNT_MAX = (SETTLE_CYC > LEARN_CYC) ? SETTLE_CYC : LEARN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int VEC_W   = LAYER_NEURONS * Z_W;

    layer_seq_state_t      state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  train_q;
    logic [SAMPLE_W-1:0]   num_samples_q;
    logic [EPOCH_W-1:0]    num_epochs_q;
    logic [SAMPLE_W-1:0]   sample_idx_q;
    logic [EPOCH_W-1:0]    epoch_idx_q;

    logic                  smp_ready_q;
    logic                  layer_valid_q;
    logic                  layer_learn_q;
    logic [N*Z_W-1:0]      layer_in_q;
    logic [VEC_W-1:0]      layer_expected_q;
    logic                  res_valid_q;
    logic [VEC_W-1:0]      res_out_q;
    logic [SAMPLE_W-1:0]   res_sample_idx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  last_smp;
    logic                  last_ep;

    assign last_smp = (sample_idx_q == num_samples_q - SAMPLE_W'(1));
    assign last_ep  = (epoch_idx_q == num_epochs_q - EPOCH_W'(1));

    assign smp_ready      = smp_ready_q;
    assign layer_valid    = layer_valid_q;
    assign layer_learn    = layer_learn_q;
    assign layer_in       = layer_in_q;
    assign layer_expected = layer_expected_q;
    assign res_valid      = res_valid_q;
    assign res_out        = res_out_q;
    assign res_sample_idx = res_sample_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign epoch_idx      = epoch_idx_q;

`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
    localparam int ERR_W = Z_W + SAMPLE_W + 4;
    localparam int SUM_W = Z_W + 4;

    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] acc_q;
    logic [ERR_W:0]   acc_ext;
    logic [ERR_W-1:0] acc_d;
    logic [ERR_W-1:0] epoch_err_q;
    logic             epoch_err_valid_q;

    zero2one_abs_err_sum u_abs_err_sum (
        .expected_i (layer_expected_q),
        .actual_i   (layer_out),
        .sum_o      (err_sum)
    );

    // Carry out of the widened add means the accumulator would wrap: clamp instead.
    assign acc_ext = {1'b0, acc_q} + {{(ERR_W + 1 - SUM_W){1'b0}}, err_sum};
    assign acc_d   = acc_ext[ERR_W] ? {ERR_W{1'b1}} : acc_ext[ERR_W-1:0];

    assign epoch_err       = epoch_err_q;
    assign epoch_err_valid = epoch_err_valid_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            train_q          <= 1'b0;
            num_samples_q    <= '0;
            num_epochs_q     <= '0;
            sample_idx_q     <= '0;
            epoch_idx_q      <= '0;
            smp_ready_q      <= 1'b0;
            layer_valid_q    <= 1'b0;
            layer_learn_q    <= 1'b0;
            layer_in_q       <= '0;
            layer_expected_q <= '0;
            res_valid_q      <= 1'b0;
            res_out_q        <= '0;
            res_sample_idx_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
            acc_q             <= '0;
            epoch_err_q       <= '0;
            epoch_err_valid_q <= 1'b0;
`endif
        end else begin
            // Strobes and pulses are single-cycle unless re-armed below.
            done_q        <= 1'b0;
            layer_valid_q <= 1'b0;
            layer_learn_q <= 1'b0;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
            epoch_err_valid_q <= 1'b0;
`endif
            if (abort) begin
                state_q     <= IDLE;
                smp_ready_q <= 1'b0;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            train_q       <= train;
                            num_samples_q <= num_samples;
                            num_epochs_q  <= num_epochs;
                            sample_idx_q  <= '0;
                            epoch_idx_q   <= '0;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
                            acc_q         <= '0;
`endif
                            if ((num_samples == '0) || (num_epochs == '0)) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= FETCH;
                                smp_ready_q <= 1'b1;
                                busy_q      <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        if (smp_valid) begin
                            layer_in_q       <= smp_in;
                            layer_expected_q <= smp_expected;
                            smp_ready_q      <= 1'b0;
                            layer_valid_q    <= 1'b1;
                            state_q          <= EVAL;
                        end
                    end
                    EVAL: begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                    end
                    SETTLE: begin
                        if (cnt_q == '0) begin
                            // Capture happens before any learn strobe, so results are pre-learn.
                            res_out_q        <= layer_out;
                            res_sample_idx_q <= sample_idx_q;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
                            acc_q            <= acc_d;
`endif
                            if (train_q) begin
                                state_q       <= LEARN;
                                layer_valid_q <= 1'b1;
                                layer_learn_q <= 1'b1;
                            end else begin
                                state_q     <= EMIT;
                                res_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    LEARN: begin
                        state_q <= HOLD;
                        cnt_q   <= CNT_W'(LEARN_CYC - 1);
                    end
                    HOLD: begin
                        if (cnt_q == '0) begin
                            state_q     <= EMIT;
                            res_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    EMIT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            if (last_smp) begin
                                sample_idx_q <= '0;
                                epoch_idx_q  <= epoch_idx_q + EPOCH_W'(1);
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
                                epoch_err_q       <= acc_q;
                                epoch_err_valid_q <= 1'b1;
                                acc_q             <= '0;
`endif
                            end else begin
                                sample_idx_q <= sample_idx_q + SAMPLE_W'(1);
                            end
                            if (last_smp && last_ep) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= FETCH;
                                smp_ready_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Randomized scoreboard bench: the driver pushes expected results on sample acceptance, a monitor pops on result handshake.
// A stand-in layer adds input, target and a learn counter per neuron so pre-learn capture is observable.
module tb_layer_train_sequencer;

    localparam int N  = 16;
    localparam int SW = 12;
    localparam int EW = 8;
    localparam int S  = 2;
    localparam int L  = 2;

    logic           clock = 1'b0;
    logic           reset, start, abort, train;
    logic [SW-1:0]  num_samples;
    logic [EW-1:0]  num_epochs;
    logic           smp_valid, smp_ready;
    logic [N*8-1:0] smp_in, layer_in;
    logic [127:0]   smp_expected, layer_expected, layer_out, res_out;
    logic           layer_valid, layer_learn, res_valid, res_ready, busy, done;
    logic [SW-1:0]  res_sample_idx;
    logic [EW-1:0]  epoch_idx;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
    logic [23:0]    epoch_err;
    logic           epoch_err_valid;
`endif

    layer_train_sequencer #(
        .N(N), .SAMPLE_W(SW), .EPOCH_W(EW), .SETTLE_CYC(S), .LEARN_CYC(L)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .train(train),
        .num_samples(num_samples), .num_epochs(num_epochs),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_in(smp_in), .smp_expected(smp_expected),
        .layer_valid(layer_valid), .layer_learn(layer_learn), .layer_in(layer_in),
        .layer_expected(layer_expected), .layer_out(layer_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_sample_idx(res_sample_idx), .busy(busy), .done(done), .epoch_idx(epoch_idx)
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
        , .epoch_err(epoch_err), .epoch_err_valid(epoch_err_valid)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] out;
        int           idx;
        int           ep;
        int           rise;
        int           err;
    } exp_t;

    exp_t       expq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         results_left = 0;
    int         done_expect_cyc = -1;
    int         last_acc = -1000;
    bit         last_tr = 1'b0;
    int         cfg_ns = 1;
    int         err_acc = 0;
    logic [7:0] learn_cnt = 8'd0;
    logic [7:0] model_learns = 8'd0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (layer_learn === 1'b1) learn_cnt <= learn_cnt + 8'd1;

    function automatic logic [127:0] layer_fn(input logic [N*8-1:0] xin, input logic [127:0] tgt, input logic [7:0] lc);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = xin[(k % N)*8 +: 8] + tgt[k*8 +: 8] + lc;
        return r;
    endfunction

    function automatic int err_fn(input logic [127:0] tgt, input logic [127:0] o);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            int a, b;
            a = int'(tgt[k*8 +: 8]);
            b = int'(o[k*8 +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    always_comb layer_out = layer_fn(layer_in, layer_expected, learn_cnt);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: strobe timing, done pulse, hold under backpressure, and result scoreboard.
    initial begin : monitor
        logic         prev_rv, prev_rr, prev_hs, exp_lv, exp_ll;
        logic [127:0] prev_out;
        logic [SW-1:0] prev_idx;
        exp_t         e;
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
        int           err_exp_cyc = -1;
        int           err_exp_val = 0;
`endif
        prev_rv = 1'b0; prev_rr = 1'b0; prev_hs = 1'b0; prev_out = '0; prev_idx = '0;
        forever begin
            @(negedge clock);
            #1;
            exp_lv = (cyc == last_acc + 1) || (last_tr && (cyc == last_acc + 2 + S));
            exp_ll = last_tr && (cyc == last_acc + 2 + S);
            chk("layer_valid", layer_valid, exp_lv);
            chk("layer_learn", layer_learn, exp_ll);
            chk("done", done, cyc == done_expect_cyc);
            if (done) chk("busy_at_done", busy, 1'b0);
            if (prev_rv && !prev_rr)
                chk("bp_hold", {res_valid, smp_ready, res_sample_idx, res_out},
                               {1'b1, 1'b0, prev_idx, prev_out});
            if (prev_hs && results_left > 0) chk("smp_ready_after_hs", smp_ready, 1'b1);
            if (res_valid && !prev_rv) begin
                if (expq.size() == 0) chk("res_valid_unexpected", res_valid, 1'b0);
                else chk("res_latency", cyc, expq[0].rise);
            end
            prev_hs = res_valid && res_ready;
            if (prev_hs) begin
                if (expq.size() == 0) begin
                    chk("result_unexpected", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("res_out", res_out, e.out);
                    chk("res_sample_idx", res_sample_idx, e.idx);
                    chk("epoch_idx", epoch_idx, e.ep);
                    chk("busy_in_emit", busy, 1'b1);
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
                    err_acc += e.err;
                    if (e.idx == cfg_ns - 1) begin
                        err_exp_cyc = cyc + 1;
                        err_exp_val = err_acc;
                        err_acc = 0;
                    end
`endif
                    results_left--;
                    if (results_left == 0) done_expect_cyc = cyc + 1;
                end
            end
`ifdef LAYER_TRAIN_SEQ_ERR_ACC_EN
            chk("epoch_err_valid", epoch_err_valid, cyc == err_exp_cyc);
            if (cyc == err_exp_cyc) chk("epoch_err", epoch_err, err_exp_val);
`endif
            prev_rv  = res_valid;
            prev_rr  = res_ready;
            prev_out = res_out;
            prev_idx = res_sample_idx;
        end
    end

    task automatic run(input bit tr, input int ns, input int ne, input int vpct, input int rpct,
                       input int bp_len, input int abort_after);
        int  budget, stall, j, first_acc;
        bit  consumed, finished;
        exp_t e;
        @(negedge clock);
        start = 1'b1; train = tr; num_samples = SW'(ns); num_epochs = EW'(ne);
        cfg_ns = ns; results_left = ns * ne; err_acc = 0;
        if (ns == 0 || ne == 0) begin
            done_expect_cyc = cyc + 1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                start = 1'b0;
                chk("zero_smp_ready", smp_ready, 1'b0);
                chk("zero_busy", busy, 1'b0);
            end
            return;
        end
        j = 0; first_acc = -1; stall = 0; consumed = 1'b0; finished = 1'b0;
        for (budget = 0; budget < 3000 && !finished; budget++) begin
            @(negedge clock);
            start = 1'b0;
            abort = 1'b0;
            if (abort_after > 0 && first_acc >= 0 && cyc == first_acc + abort_after) begin
                abort = 1'b1;
                void'(expq.pop_back());
                results_left = 0;
                @(negedge clock);
                abort = 1'b0;
                smp_valid = 1'b0;
                chk("abort_busy", busy, 1'b0);
                chk("abort_res_valid", res_valid, 1'b0);
                chk("abort_smp_ready", smp_ready, 1'b0);
                finished = 1'b1;
            end else if (results_left == 0 && done_expect_cyc >= 0 && cyc > done_expect_cyc) begin
                finished = 1'b1;
            end else begin
                if (consumed) begin
                    smp_valid = 1'b0;
                    consumed = 1'b0;
                end
                if (!smp_valid && $urandom_range(0, 99) < vpct) begin
                    smp_valid = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        smp_in[k*32 +: 32]       = $urandom;
                        smp_expected[k*32 +: 32] = $urandom;
                    end
                end
                if (smp_valid && smp_ready) begin
                    e.out  = layer_fn(smp_in, smp_expected, model_learns);
                    e.idx  = j % ns;
                    e.ep   = j / ns;
                    e.rise = cyc + 2 + S + (tr ? 1 + L : 0);
                    e.err  = err_fn(smp_expected, e.out);
                    expq.push_back(e);
                    if (tr) model_learns = model_learns + 8'd1;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    last_tr  = tr;
                    j++;
                    consumed = 1'b1;
                end
                if (res_valid && stall < bp_len) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = ($urandom_range(0, 99) < rpct);
                    if (res_valid && res_ready) stall = 0;
                end
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL run_timeout: actual=no completion expected=completion within 3000 cycles");
        end
        smp_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin : main
        reset = 1'b1; start = 1'b0; abort = 1'b0; train = 1'b0;
        num_samples = '0; num_epochs = '0; smp_valid = 1'b0; res_ready = 1'b0;
        smp_in = '0; smp_expected = '0;
        repeat (3) @(negedge clock);
        chk("rst_smp_ready", smp_ready, 1'b0);
        chk("rst_layer_valid", layer_valid, 1'b0);
        chk("rst_layer_learn", layer_learn, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_epoch_idx", epoch_idx, 0);
        chk("rst_res_idx", res_sample_idx, 0);
        chk("rst_res_out", res_out, 0);
        chk("rst_layer_in", layer_in, 0);
        chk("rst_layer_exp", layer_expected, 0);
        reset = 1'b0;

        run(1'b0, 3, 1, 100, 100, 0, 0);   // inference, always-valid source
        run(1'b1, 2, 1, 100, 100, 0, 0);   // training latency
        run(1'b1, 3, 1, 100, 100, 5, 0);   // 5-cycle result backpressure
        run(1'b0, 2, 3, 100, 100, 0, 0);   // epoch wrap
        run(1'b0, 0, 3, 100, 100, 0, 0);   // zero samples
        run(1'b1, 2, 0, 100, 100, 0, 0);   // zero epochs
        run(1'b0, 3, 1, 100, 100, 0, 2);   // abort in SETTLE
        run(1'b0, 2, 1, 100, 100, 0, 0);   // restart from index 0
        for (int r = 0; r < 6; r++)
            run(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(40, 100), $urandom_range(40, 100), 0, 0);

        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
